// File: rtl/cpu_seq_pkg.sv
// Shared state encoding and defaults for the multi-cycle RV32I sequencer.
// Pure definitions: no latency, no handshake.
package cpu_seq_pkg;

  localparam int SEQ_STATE_W     = 3;
  localparam int DEF_MEM_TIMEOUT = 15;

  typedef enum logic [SEQ_STATE_W-1:0] {
    IDLE   = 3'd0,
    FETCH  = 3'd1,
    DECODE = 3'd2,
    EXEC   = 3'd3,
    MEM    = 3'd4,
    WB     = 3'd5,
    HALT   = 3'd6,
    ERROR  = 3'd7
  } seq_state_e;

endpackage

// File: rtl/multicycle_sequencer_if.sv
// Decoder/datapath/memory signals of the sequencer, bundled for one port.
// master = sequencer side, slave = datapath, decoder and memory side.
interface multicycle_sequencer_if #(
  parameter int CNT_W = 32
);
  import cpu_seq_pkg::*;

  logic                   run_en;
  logic                   reg_write_dec;
  logic                   dm_write_dec;
  logic                   is_load_dec;
  logic                   hlt_dec;
  logic                   imem_ready;
  logic                   dmem_ready;
  logic                   imem_req;
  logic                   dmem_req;
  logic                   dmem_we;
  logic                   ir_we;
  logic                   pc_we;
  logic                   rf_we;
  logic [SEQ_STATE_W-1:0] state;
  logic                   halted;
  logic                   bus_error;
  logic [CNT_W-1:0]       instret;

  modport master (
    input  run_en, reg_write_dec, dm_write_dec, is_load_dec, hlt_dec,
           imem_ready, dmem_ready,
    output imem_req, dmem_req, dmem_we, ir_we, pc_we, rf_we,
           state, halted, bus_error, instret
  );

  modport slave (
    output run_en, reg_write_dec, dm_write_dec, is_load_dec, hlt_dec,
           imem_ready, dmem_ready,
    input  imem_req, dmem_req, dmem_we, ir_we, pc_we, rf_we,
           state, halted, bus_error, instret
  );

endinterface

// File: rtl/seq_wait_timer.sv
// Wait-state counter shared by fetch and data accesses; timeout is combinational
// in the cycle the count sits at MEM_TIMEOUT with ready low (ready that cycle wins).
module seq_wait_timer
  import cpu_seq_pkg::*;
#(
  parameter int MEM_TIMEOUT = DEF_MEM_TIMEOUT
) (
  input  logic clk,
  input  logic rst_n,
  input  logic clear,
  input  logic busy,
  input  logic ready,
  output logic timeout
);

  localparam int            CW    = (MEM_TIMEOUT > 1) ? $clog2(MEM_TIMEOUT + 1) : 1;
  localparam logic [CW-1:0] LIMIT = CW'(MEM_TIMEOUT);

  logic [CW-1:0] cnt_q;
  logic          at_limit;
  logic          stalled;

  assign at_limit = (cnt_q == LIMIT);
  assign stalled  = busy && !ready;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q <= '0;
    end else if (clear) begin
      cnt_q <= '0;
    end else if (stalled && !at_limit) begin
      cnt_q <= cnt_q + CW'(1);
    end
  end

  // A zero limit keeps the counter parked at zero and never fires.
  assign timeout = (MEM_TIMEOUT != 0) && stalled && at_limit;

endmodule

// File: rtl/multicycle_sequencer.sv
// FETCH/DECODE/EXEC/MEM/WB control FSM; registered state, strobes combinational.
// Fetch and data requests are held until their ready, bounded by the wait timer.
module multicycle_sequencer
  import cpu_seq_pkg::*;
#(
  parameter int MEM_TIMEOUT = DEF_MEM_TIMEOUT,
  parameter int CNT_W       = 32
) (
  input  logic                   clk,
  input  logic                   rst_n,
  multicycle_sequencer_if.master bus
);

  seq_state_e       state_q;
  seq_state_e       state_d;
  logic             ir_we;
  logic             pc_we;
  logic             rf_we;
  logic             imem_req;
  logic             dmem_req;
  logic             dmem_we;
  logic             timer_clear;
  logic             timer_busy;
  logic             timer_ready;
  logic             timeout;
  logic [CNT_W-1:0] instret_q;
  seq_state_e       boundary_next;

  // Where an instruction goes once it has retired.
  assign boundary_next = bus.run_en ? FETCH : IDLE;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d  = state_q;
    ir_we    = 1'b0;
    pc_we    = 1'b0;
    rf_we    = 1'b0;
    imem_req = 1'b0;
    dmem_req = 1'b0;
    dmem_we  = 1'b0;
    case (state_q)
      IDLE: begin
        if (bus.run_en) state_d = FETCH;
      end
      FETCH: begin
        imem_req = 1'b1;
        if (bus.imem_ready) begin
          ir_we   = 1'b1;
          state_d = DECODE;
        end else if (timeout) begin
          state_d = ERROR;
        end
      end
      DECODE: begin
        state_d = bus.hlt_dec ? HALT : EXEC;
      end
      EXEC: begin
        if (bus.is_load_dec || bus.dm_write_dec) begin
          state_d = MEM;
        end else if (bus.reg_write_dec) begin
          state_d = WB;
        end else begin
          pc_we   = 1'b1;
          state_d = boundary_next;
        end
      end
      MEM: begin
        dmem_req = 1'b1;
        dmem_we  = bus.dm_write_dec;
        if (bus.dmem_ready) begin
          // A store flag overrides a load flag: no writeback.
          if (bus.dm_write_dec) begin
            pc_we   = 1'b1;
            state_d = boundary_next;
          end else begin
            state_d = WB;
          end
        end else if (timeout) begin
          state_d = ERROR;
        end
      end
      WB: begin
        rf_we   = 1'b1;
        pc_we   = 1'b1;
        state_d = boundary_next;
      end
      HALT:    state_d = HALT;
      ERROR:   state_d = ERROR;
      default: state_d = IDLE;
    endcase
  end

  // Restart the wait count on every entry into a request state.
  assign timer_clear = ((state_d == FETCH) && (state_q != FETCH)) ||
                       ((state_d == MEM)   && (state_q != MEM));
  assign timer_busy  = imem_req || dmem_req;
  assign timer_ready = (imem_req && bus.imem_ready) || (dmem_req && bus.dmem_ready);

  seq_wait_timer #(
    .MEM_TIMEOUT (MEM_TIMEOUT)
  ) u_wait_timer (
    .clk     (clk),
    .rst_n   (rst_n),
    .clear   (timer_clear),
    .busy    (timer_busy),
    .ready   (timer_ready),
    .timeout (timeout)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      instret_q <= '0;
    end else if (pc_we) begin
      instret_q <= instret_q + CNT_W'(1);
    end
  end

  assign bus.imem_req  = imem_req;
  assign bus.dmem_req  = dmem_req;
  assign bus.dmem_we   = dmem_we;
  assign bus.ir_we     = ir_we;
  assign bus.pc_we     = pc_we;
  assign bus.rf_we     = rf_we;
  assign bus.state     = state_q;
  assign bus.halted    = (state_q == HALT);
  assign bus.bus_error = (state_q == ERROR);
  assign bus.instret   = instret_q;

endmodule

// File: tb/tb_multicycle_sequencer.sv
// Directed and randomized instruction mixes against a per-instruction cost model.
module tb_multicycle_sequencer;
  import cpu_seq_pkg::*;

  logic clk = 1'b0;
  logic rst_n;
  int   tests = 0;
  int   fails = 0;
  int   exp_instret = 0;
  int   trace[$];

  always #5 clk = ~clk;

  multicycle_sequencer_if #(.CNT_W(32)) bus ();

  multicycle_sequencer #(.MEM_TIMEOUT(15), .CNT_W(32)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: got %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic check_idle(input string tag);
    check({tag, "_state"}, 32'(bus.state), 0);
    check({tag, "_strobes"}, {26'd0, bus.imem_req, bus.dmem_req, bus.dmem_we,
                              bus.ir_we, bus.pc_we, bus.rf_we}, 0);
    check({tag, "_flags"}, {30'd0, bus.halted, bus.bus_error}, 0);
    check({tag, "_instret"}, bus.instret, 0);
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    bus.run_en = 1'b0; bus.reg_write_dec = 1'b0; bus.dm_write_dec = 1'b0;
    bus.is_load_dec = 1'b0; bus.hlt_dec = 1'b0;
    bus.imem_ready = 1'b0; bus.dmem_ready = 1'b0;
    repeat (2) @(negedge clk);
    #1;
    check_idle("reset");
    @(negedge clk);
    rst_n = 1'b1;
    exp_instret = 0;
  endtask

  // cls: 0 branch, 1 alu, 2 load, 3 store, 4 load+store flags
  task automatic run_instr(input int cls, input int wi, input int wd, input bit drop_run);
    bit ld, st, rw, mem, wb, started, done;
    int cyc, fcnt, mcnt, n_ir, n_pc, n_rf, n_dreq, n_dwe, exp_cyc;
    ld  = (cls == 2) || (cls == 4);
    st  = (cls == 3) || (cls == 4);
    rw  = (cls == 1) || (cls == 2) || (cls == 4);
    mem = ld || st;
    wb  = mem ? !st : rw;
    exp_cyc = (wi + 1) + 2 + (mem ? wd + 1 : 0) + (wb ? 1 : 0);
    bus.is_load_dec = ld; bus.dm_write_dec = st; bus.reg_write_dec = rw;
    bus.hlt_dec = 1'b0; bus.run_en = 1'b1;
    started = 0; done = 0;
    cyc = 0; fcnt = 0; mcnt = 0; n_ir = 0; n_pc = 0; n_rf = 0; n_dreq = 0; n_dwe = 0;
    trace.delete();
    for (int c = 0; c < 200 && !done; c++) begin
      @(negedge clk);
      if (bus.state == FETCH) started = 1;
      if (started && drop_run && bus.state == DECODE) bus.run_en = 1'b0;
      bus.imem_ready = bus.imem_req ? (fcnt == wi) : 1'($urandom);
      bus.dmem_ready = bus.dmem_req ? (mcnt == wd) : 1'($urandom);
      if (bus.imem_req) fcnt++;
      if (bus.dmem_req) mcnt++;
      #1;
      if (started) begin
        cyc++;
        trace.push_back(int'(bus.state));
        n_ir   += int'(bus.ir_we);
        n_pc   += int'(bus.pc_we);
        n_rf   += int'(bus.rf_we);
        n_dreq += int'(bus.dmem_req);
        n_dwe  += int'(bus.dmem_we);
        check("inv_ir_rf", 32'(bus.ir_we && bus.rf_we), 0);
        check("inv_dwe", 32'(bus.dmem_we && !bus.dmem_req), 0);
        if (bus.pc_we) done = 1;
      end
    end
    check("instr_done", 32'(done), 1);
    check("instr_cycles", cyc, exp_cyc);
    check("ir_we_count", n_ir, 1);
    check("pc_we_count", n_pc, 1);
    check("rf_we_count", n_rf, wb ? 1 : 0);
    check("dmem_req_cycles", n_dreq, mem ? wd + 1 : 0);
    check("dmem_we_cycles", n_dwe, st ? wd + 1 : 0);
    exp_instret++;
    @(posedge clk);
    #1;
    check("instret", bus.instret, exp_instret);
    check("boundary_state", 32'(bus.state), drop_run ? 0 : 1);
  endtask

  task automatic run_timeout(input bit give_ready);
    int  n;
    bit  seen;
    do_reset();
    bus.run_en = 1'b1;
    seen = 0;
    for (int c = 0; c < 10 && !seen; c++) begin
      @(negedge clk);
      bus.imem_ready = 1'b0;
      #1;
      if (bus.state == FETCH) seen = 1;
    end
    check("to_fetch_seen", 32'(seen), 1);
    n = 0;
    seen = 0;
    for (int c = 0; c < 40 && !seen; c++) begin
      @(negedge clk);
      n++;
      bus.imem_ready = give_ready && (n == 15);
      bus.dmem_ready = 1'($urandom);
      #1;
      if (bus.state == ERROR || bus.state == DECODE) seen = 1;
    end
    check("to_cycles", n, 16);
    check("to_state", 32'(bus.state), give_ready ? 2 : 7);
    check("to_bus_error", 32'(bus.bus_error), give_ready ? 0 : 1);
    if (!give_ready) begin
      for (int c = 0; c < 5; c++) begin
        @(negedge clk);
        bus.imem_ready = 1'($urandom);
        bus.dmem_ready = 1'($urandom);
        #1;
        check("err_quiet", {26'd0, bus.imem_req, bus.dmem_req, bus.dmem_we,
                            bus.ir_we, bus.pc_we, bus.rf_we}, 0);
        check("err_sticky", 32'(bus.state), 7);
      end
    end
  endtask

  initial begin
    int  n_pc;
    bit  seen;
    rst_n = 1'b0;
    do_reset();

    // ALU op, zero-wait: 1,2,3,5 then retire
    run_instr(1, 0, 0, 0);
    check("alu_trace_len", trace.size(), 4);
    if (trace.size() == 4) begin
      check("alu_trace0", trace[0], 1);
      check("alu_trace1", trace[1], 2);
      check("alu_trace2", trace[2], 3);
      check("alu_trace3", trace[3], 5);
    end
    run_instr(2, 0, 3, 0);
    run_instr(3, 0, 1, 0);

    do_reset();
    for (int i = 0; i < 5; i++) run_instr(0, 0, 0, 0);
    check("five_branches", bus.instret, 5);

    run_instr(1, 2, 0, 1);
    for (int i = 0; i < 40; i++) begin
      run_instr(int'($urandom_range(0, 4)), int'($urandom_range(0, 4)),
                int'($urandom_range(0, 4)), ($urandom_range(0, 5) == 0));
    end

    // Halt: sticky, no retirement, reset clears it
    do_reset();
    bus.hlt_dec = 1'b1;
    bus.run_en = 1'b1;
    n_pc = 0;
    seen = 0;
    for (int c = 0; c < 20 && !seen; c++) begin
      @(negedge clk);
      bus.imem_ready = bus.imem_req;
      bus.dmem_ready = 1'b0;
      #1;
      n_pc += int'(bus.pc_we);
      if (bus.state == HALT) seen = 1;
    end
    check("halt_reached", 32'(seen), 1);
    for (int c = 0; c < 20; c++) begin
      @(negedge clk);
      bus.imem_ready = 1'($urandom);
      bus.dmem_ready = 1'($urandom);
      bus.run_en = 1'($urandom);
      #1;
      n_pc += int'(bus.pc_we);
      check("halt_sticky", {30'd0, bus.halted, bus.bus_error}, 2);
    end
    check("halt_state", 32'(bus.state), 6);
    check("halt_no_pc_we", n_pc, 0);
    check("halt_instret", bus.instret, 0);
    rst_n = 1'b0;
    #1;
    check_idle("halt_rst");

    run_timeout(1'b0);
    run_timeout(1'b1);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
